// File: rtl/servant_uart_mon_if.sv
// Serial line and receive-side outputs of the servant UART monitor.
// master: the side that drives the line and consumes the decoded bytes.
// slave:  the monitor itself.
interface servant_uart_mon_if;
  logic        q;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        rx_ferr;
  logic        rx_busy;
  logic [31:0] rx_cnt;

  modport master (output q, input rx_data, rx_vld, rx_ferr, rx_busy, rx_cnt);
  modport slave  (input q, output rx_data, rx_vld, rx_ferr, rx_busy, rx_cnt);
endinterface

// File: rtl/servant_uart_mon.sv
// 8N1 receiver for the servant q output. Every decision is taken on the
// registered copy q_r. A byte is reported with a one-cycle rx_vld strobe;
// a low stop bit gives a one-cycle rx_ferr strobe and parks the receiver
// until the line returns high.
module servant_uart_mon #(
  parameter int clks_per_bit = 278,
  parameter int sim          = 0
) (
  input logic               wb_clk,
  input logic               wb_rst,
  servant_uart_mon_if.slave bus
);
  localparam int CW   = $clog2(clks_per_bit);
  localparam int half = clks_per_bit / 2;
  localparam logic [CW-1:0] START_END = CW'(half - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(clks_per_bit - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state, state_d;
  logic          q_r;
  logic          armed;
  logic [CW-1:0] ctr;
  logic [3:0]    bitn;
  logic [7:0]    shreg;
  logic [7:0]    rx_data;
  logic          rx_vld;
  logic          rx_ferr;
  logic [31:0]   rx_cnt;

  logic start_end, bit_end;
  assign start_end = (ctr == START_END);
  assign bit_end   = (ctr == BIT_END);

  // State register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state decode: start qualification, 8 data bits, stop check, break hold.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (armed && !q_r) state_d = START;
      START:   if (start_end) state_d = q_r ? IDLE : DATA;
      DATA:    if (bit_end && bitn == 4'd7) state_d = STOP;
      STOP:    if (bit_end) state_d = q_r ? IDLE : BRK;
      BRK:     if (q_r) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: line register, bit timing, shift register, strobes and byte count.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      q_r     <= 1'b1;
      armed   <= 1'b0;
      ctr     <= '0;
      bitn    <= '0;
      shreg   <= '0;
      rx_data <= '0;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      rx_cnt  <= '0;
    end else begin
      q_r     <= bus.q;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      case (state)
        IDLE: begin
          ctr <= '0;
          if (q_r) armed <= 1'b1;
        end
        START: begin
          if (start_end) begin
            ctr  <= '0;
            bitn <= '0;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            // LSB arrives first, so shift in from the top.
            shreg <= {q_r, shreg[7:1]};
            ctr   <= '0;
            bitn  <= bitn + 4'd1;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            ctr <= '0;
            if (q_r) begin
              rx_data <= shreg;
              rx_vld  <= 1'b1;
              rx_cnt  <= rx_cnt + 32'd1;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        BRK: begin
          // Disarmed while the line is held low; re-armed by the high that exits.
          armed <= q_r;
        end
        default: ctr <= '0;
      endcase
    end
  end

  assign bus.rx_data = rx_data;
  assign bus.rx_vld  = rx_vld;
  assign bus.rx_ferr = rx_ferr;
  assign bus.rx_cnt  = rx_cnt;
  assign bus.rx_busy = (state == START) || (state == DATA) || (state == STOP);

  // Console echo of decoded bytes in simulation builds.
  generate
    if (sim != 0) begin : g_sim
      always @(posedge wb_clk) if (rx_vld) $write("%c", rx_data);
    end
  endgenerate
endmodule

// File: tb/tb_servant_uart_mon.sv
// Bench for servant_uart_mon at 8 clocks per bit. Frames are driven on the
// line, the expected strobe (kind, cycle, byte, count) of each frame is
// derived from the frame itself, and observed strobes are compared in order.
module tb_servant_uart_mon;
  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  localparam int LAT  = HALF + 9 * CPB + 1;  // line-low edge to strobe cycle

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  servant_uart_mon_if bus();

  servant_uart_mon #(.clks_per_bit(CPB), .sim(0)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus)
  );

  always #5 wb_clk = ~wb_clk;

  int cyc = 0;
  always @(posedge wb_clk) cyc <= cyc + 1;

  typedef struct {
    bit          ferr;
    int          c;
    logic [7:0]  d;
    logic [31:0] n;
  } ev_t;

  ev_t act_q[$];
  ev_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  m_data = 8'h00;
  logic [31:0] m_cnt  = 32'd0;

  // Record every strobe the DUT produces.
  always @(negedge wb_clk) begin
    if (bus.rx_vld || bus.rx_ferr) begin
      vectors++;
      assert (!(bus.rx_vld && bus.rx_ferr)) else begin
        miscompares++;
        $error("FAIL excl: observed vld=%b ferr=%b, expected not both", bus.rx_vld, bus.rx_ferr);
      end
      act_q.push_back('{bus.rx_ferr, cyc, bus.rx_data, bus.rx_cnt});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.q = v;
    repeat (CPB) @(negedge wb_clk);
  endtask

  task automatic idle(input int n);
    bus.q = 1'b1;
    repeat (n) @(negedge wb_clk);
  endtask

  // One 8N1 frame; a bad stop bit can be stretched low by extra_low cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
    int fall;
    fall = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (!stop_ok) repeat (extra_low) @(negedge wb_clk);
    bus.q = 1'b1;
    if (stop_ok) begin
      m_data = b;
      m_cnt  = m_cnt + 32'd1;
      exp_q.push_back('{1'b0, fall + LAT, b, m_cnt});
    end else begin
      exp_q.push_back('{1'b1, fall + LAT, m_data, m_cnt});
    end
  endtask

  task automatic check_events(input string tag);
    ev_t e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_present"}, 32'(act_q.size() > 0), 32'd1);
      if (act_q.size() > 0) begin
        a = act_q.pop_front();
        chk({tag, "_kind"}, 32'(a.ferr), 32'(e.ferr));
        chk({tag, "_cycle"}, 32'(a.c), 32'(e.c));
        chk({tag, "_data"}, 32'(a.d), 32'(e.d));
        chk({tag, "_cnt"}, a.n, e.n);
      end
    end
    chk({tag, "_extra"}, 32'(act_q.size()), 32'd0);
    act_q.delete();
  endtask

  task automatic do_reset();
    @(negedge wb_clk);
    wb_rst = 1'b1;
    repeat (2) @(negedge wb_clk);
    chk("rst_data", 32'(bus.rx_data), 32'd0);
    chk("rst_vld",  32'(bus.rx_vld),  32'd0);
    chk("rst_ferr", 32'(bus.rx_ferr), 32'd0);
    chk("rst_busy", 32'(bus.rx_busy), 32'd0);
    chk("rst_cnt",  bus.rx_cnt,       32'd0);
    wb_rst = 1'b0;
    m_data = 8'h00;
    m_cnt  = 32'd0;
    exp_q.delete();
    act_q.delete();
  endtask

  initial begin
    int busy_n;
    int vld_n;
    logic [7:0] b;
    bus.q = 1'b1;

    // Reset state, then arm on an idle line.
    do_reset();
    idle(4);

    // Single well-formed byte.
    send_frame(8'h55, 1'b1, 0);
    idle(4);
    check_events("b55");

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    idle(4);
    check_events("b2b");
    chk("b2b_cnt", bus.rx_cnt, 32'd3);

    // Short low glitch must be rejected at the start-bit sample.
    busy_n = 0;
    bus.q = 1'b0;
    repeat (3) begin
      @(negedge wb_clk);
      busy_n += int'(bus.rx_busy);
    end
    bus.q = 1'b1;
    repeat (20) begin
      @(negedge wb_clk);
      busy_n += int'(bus.rx_busy);
    end
    chk("glitch_busy", 32'(busy_n inside {[1:4]}), 32'd1);
    check_events("glitch");
    chk("glitch_cnt", bus.rx_cnt, m_cnt);

    // Framing error with line held low, then recovery.
    send_frame(8'hA5, 1'b0, 20);
    idle(6);
    check_events("ferr");
    chk("ferr_hold", 32'(bus.rx_data), 32'(m_data));
    send_frame(8'h3C, 1'b1, 0);
    idle(4);
    check_events("recov");

    // Reset during data bit 4 with the line then held low.
    b = 8'h6B;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    bus.q = b[4];
    repeat (3) @(negedge wb_clk);
    bus.q = 1'b0;
    do_reset();
    bus.q = 1'b0;
    repeat (100) @(negedge wb_clk);
    vld_n = 0;
    foreach (act_q[i]) if (!act_q[i].ferr) vld_n++;
    chk("rstlow_novld", 32'(vld_n), 32'd0);
    chk("rstlow_cnt", bus.rx_cnt, 32'd0);
    act_q.delete();
    idle(4);
    send_frame(8'hC3, 1'b1, 0);
    idle(4);
    check_events("post_rst");

    // Randomised traffic with occasional bad stop bits.
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 7) != 0) begin
        send_frame(b, 1'b1, 0);
        idle($urandom_range(0, 6));
      end else begin
        send_frame(b, 1'b0, $urandom_range(0, 15));
        idle($urandom_range(2, 8));
      end
    end
    idle(4);
    check_events("rand");

    // "Hi\n" from a fresh reset.
    do_reset();
    idle(4);
    send_frame(8'h48, 1'b1, 0);
    send_frame(8'h69, 1'b1, 0);
    idle(2);
    send_frame(8'h0A, 1'b1, 0);
    idle(4);
    check_events("hi");
    chk("hi_cnt", bus.rx_cnt, 32'd3);
    chk("hi_last", 32'(bus.rx_data), 32'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
